// File: rtl/mem_responder_if.sv
// Request/response bus of mem_responder: request code, byte address and the
// three status strobes. The bidirectional DataIO bus is a plain inout port on
// the block so that tristate resolution stays on an ordinary module boundary.
interface mem_responder_if;
  logic [1:0]  MemIO;
  logic [31:0] ALUAddr;
  logic        ValidMemData;
  logic        MemBusy;
  logic        AddrFault;

  modport master (
    output MemIO,
    output ALUAddr,
    input  ValidMemData,
    input  MemBusy,
    input  AddrFault
  );

  modport slave (
    input  MemIO,
    input  ALUAddr,
    output ValidMemData,
    output MemBusy,
    output AddrFault
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states. A read or write
// is latched in IDLE, held for WAIT_STATES+1 edges, completed with a one-cycle
// ValidMemData/AddrFault pulse in DONE, then parked in RELEASE until the
// requester drops its request so a held request is serviced only once.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus,
  inout  wire [31:0]     DataIO
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;
  logic            drive_q, drive_d;

  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [DEPTH];

  logic                  bad_addr;
  logic                  finish;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] idx;

  // Address decode and commit strobes for the edge that leaves WAIT.
  assign bad_addr = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign idx      = addr_q[ADDR_WIDTH+1:2];
  assign finish   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_we   = finish && wr_q && !bad_addr;
  assign ram_re   = finish && !wr_q && !bad_addr;

  // Next-state, counter and next registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    drive_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MemIO == 2'b01 || bus.MemIO == 2'b10) begin
          state_d = WAIT;
          cnt_d   = WS_INIT;
          addr_d  = bus.ALUAddr;
          wdata_d = DataIO;
          wr_d    = (bus.MemIO == 2'b10);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          valid_d = !bad_addr;
          fault_d = bad_addr;
          drive_d = ram_re;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (bus.MemIO == 2'b00 || bus.MemIO == 2'b11) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered status outputs; reset aborts any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      drive_q <= drive_d;
    end
  end

  // Request latches, RAM commit and read capture; RAM survives reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
    if (ram_we) begin
      mem[idx] <= wdata_q;
    end
    if (ram_re) begin
      rdata_q <= mem[idx];
    end
  end

  assign bus.ValidMemData = valid_q;
  assign bus.AddrFault    = fault_q;
  assign bus.MemBusy      = busy_q;
  assign DataIO           = drive_q ? rdata_q : 32'bz;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) driven with
// directed and random requests; a monitor pops expected completions from a
// per-instance scoreboard fed by a word-array memory model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if bus0();
  mem_responder_if bus1();
  wire [31:0] dio0;
  wire [31:0] dio1;

  logic [1:0]  memio [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic        tbdrv [2];
  logic        v [2];
  logic        f [2];
  logic        b [2];
  logic [31:0] dio [2];

  assign bus0.MemIO   = memio[0];
  assign bus0.ALUAddr = addr[0];
  assign bus1.MemIO   = memio[1];
  assign bus1.ALUAddr = addr[1];
  assign dio0 = tbdrv[0] ? wdat[0] : 32'bz;
  assign dio1 = tbdrv[1] ? wdat[1] : 32'bz;
  assign v[0] = bus0.ValidMemData;
  assign f[0] = bus0.AddrFault;
  assign b[0] = bus0.MemBusy;
  assign v[1] = bus1.ValidMemData;
  assign f[1] = bus1.AddrFault;
  assign b[1] = bus1.MemBusy;
  assign dio[0] = dio0;
  assign dio[1] = dio1;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .DataIO(dio0)
  );
  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .DataIO(dio1)
  );

  typedef struct {
    bit          fault;
    bit          rd;
    bit          known;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] refm [2][1024];
  bit          wrn  [2][1024];

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic exp_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference model: a word is addressable only when aligned and below 4 KiB.
  function automatic void push_exp(input int k, input logic [1:0] code,
                                   input logic [31:0] a, input logic [31:0] d, input int when);
    exp_t e;
    int   w;
    w       = int'(a / 4) % 1024;
    e.fault = (a % 4 != 0) || (a >= 32'd4096);
    e.rd    = (code == 2'b01);
    e.known = 1'b0;
    e.data  = 32'd0;
    e.cyc   = when;
    if (!e.fault) begin
      if (code == 2'b10) begin
        refm[k][w] = d;
        wrn[k][w]  = 1'b1;
      end else begin
        e.data  = refm[k][w];
        e.known = wrn[k][w];
      end
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    exp_t e;
    bit   rd_pulse;
    rd_pulse = 1'b0;
    if (!rst_n) begin
      chk("reset_outs", k, {29'd0, v[k], f[k], b[k]}, 32'd0);
      chk("reset_dio_z", k, dio[k], 32'bz);
      return;
    end
    chk("valid_and_fault", k, 32'(v[k] & f[k]), 32'd0);
    while (qsize(k) > 0) begin
      e = qfront(k);
      if (e.cyc >= cyc) break;
      chk("missed_pulse", k, 32'd0, 32'd1);
      e = qpop(k);
    end
    if (v[k] || f[k]) begin
      if (qsize(k) == 0) begin
        chk("unexpected_pulse", k, 32'd1, 32'd0);
      end else begin
        e = qpop(k);
        chk("fault_flag", k, 32'(f[k]), 32'(e.fault));
        chk("latency_cyc", k, 32'(cyc), 32'(e.cyc));
        if (e.rd && !e.fault) begin
          rd_pulse = 1'b1;
          if (e.known) chk("read_data", k, dio[k], e.data);
        end
      end
    end
    if (!rd_pulse && !tbdrv[k]) chk("dio_z", k, dio[k], 32'bz);
  endtask

  // Monitor: sample both instances just after each falling edge.
  always begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_inst(k);
  end

  // Entered and left at a falling edge; issues one request and lets it retire.
  task automatic do_req(input int k, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    int n;
    n = 0;
    while (b[k] && n < 50) begin @(negedge clk); n++; end
    if (b[k]) begin
      chk("idle_timeout", k, 32'd1, 32'd0);
      return;
    end
    memio[k] = code;
    addr[k]  = a;
    if (code == 2'b10) begin
      wdat[k]  = d;
      tbdrv[k] = 1'b1;
    end
    push_exp(k, code, a, d, cyc + ws(k) + 2);
    @(negedge clk);
    chk("busy_after_accept", k, 32'(b[k]), 32'd1);
    addr[k] = $urandom;
    if (tbdrv[k]) wdat[k] = $urandom;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("busy_held", k, 32'(b[k]), 32'd1);
    end
    memio[k] = ($urandom % 2 == 0) ? 2'b00 : 2'b11;
    n = 0;
    while (b[k] && n < 40) begin @(negedge clk); n++; end
    chk("release_idle", k, 32'(b[k]), 32'd0);
    tbdrv[k] = 1'b0;
    memio[k] = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          k;
    int          r;
    for (int i = 0; i < 2; i++) begin
      memio[i] = 2'b00;
      addr[i]  = 32'd0;
      wdat[i]  = 32'd0;
      tbdrv[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read with wait states, then with zero wait states.
    do_req(0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 2'b01, 32'h10, 32'd0, 0);
    do_req(1, 2'b10, 32'h0, 32'h12345678, 0);
    do_req(1, 2'b01, 32'h0, 32'd0, 0);

    // Faulty addresses leave the RAM untouched.
    do_req(0, 2'b10, 32'h11, 32'h0BADF00D, 0);
    do_req(0, 2'b10, 32'h1000, 32'h0BADF00D, 0);
    do_req(0, 2'b01, 32'h10, 32'd0, 0);

    // Held request is serviced once.
    do_req(0, 2'b01, 32'h10, 32'd0, 10);
    do_req(1, 2'b01, 32'h0, 32'd0, 6);

    // Code 11 in IDLE is ignored.
    memio[0] = 2'b11;
    memio[1] = 2'b11;
    repeat (4) begin
      @(negedge clk);
      chk("ignore11_busy", 0, 32'(b[0]), 32'd0);
      chk("ignore11_busy", 1, 32'(b[1]), 32'd0);
    end
    memio[0] = 2'b00;
    memio[1] = 2'b00;
    @(negedge clk);

    // Reset during the WAIT of a write aborts it.
    do_req(0, 2'b10, 32'h20, 32'h11111111, 0);
    memio[0] = 2'b10;
    addr[0]  = 32'h20;
    wdat[0]  = 32'hA5A5A5A5;
    tbdrv[0] = 1'b1;
    @(negedge clk);
    wdat[0] = 32'h5A5A5A5A;
    @(negedge clk);
    rst_n    = 1'b0;
    memio[0] = 2'b00;
    tbdrv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(b[0]), 32'd0);
    rst_n = 1'b1;
    do_req(0, 2'b01, 32'h20, 32'd0, 0);

    // Random traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom % 2);
      r = int'($urandom % 8);
      a = 32'($urandom % 16) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'd1 << $urandom_range(12, 31));
      do_req(k, ($urandom % 2 == 0) ? 2'b01 : 2'b10, a, $urandom, int'($urandom % 4));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 0, 32'(qsize(0)), 32'd0);
    chk("sb_empty", 1, 32'(qsize(1)), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the word-address width; internal RAM depth is 2^ADDR_WIDTH x 32 bits.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the extra wait cycles per access; legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port MemIO, input, 2 bits: request code; 00 NOP, 01 read, 10 write, 11 data-to-GPR (not a memory request).
REQ-006 The block SHALL have port ALUAddr, input, 32 bits: byte address of the request.
REQ-007 The block SHALL have port DataIO, inout, 32 bits: write data in, read data out; driven only as REQ-018 allows, otherwise high-Z.
REQ-008 The block SHALL have port ValidMemData, output, 1 bit: one-cycle completion pulse for a good read or write.
REQ-009 The block SHALL have port MemBusy, output, 1 bit: high while a request is in progress or awaiting release.
REQ-010 The block SHALL have port AddrFault, output, 1 bit: one-cycle pulse that replaces ValidMemData on a bad address.

Function
REQ-011 The block SHALL implement the FSM states IDLE, WAIT, DONE and RELEASE.
REQ-012 In IDLE, when MemIO is 01 or 10 at a rising edge, the block SHALL latch ALUAddr, MemIO and DataIO (write data), go to WAIT, and load the wait counter with WAIT_STATES.
REQ-013 In IDLE, MemIO values 00 and 11 SHALL be ignored, and all outputs SHALL stay low with DataIO at high-Z.
REQ-014 In WAIT, the counter SHALL decrement each edge; the block SHALL go to DONE on the edge where the counter is 0, so WAIT_STATES=0 reaches DONE one edge after accept.
REQ-015 ValidMemData or AddrFault SHALL be high only in DONE, which lasts exactly one cycle; latency is WAIT_STATES+1 edges after the accepting edge.
REQ-016 The address SHALL be faulty if ALUAddr[1:0] != 0 or any bit of ALUAddr[31:ADDR_WIDTH+2] is set; the word index is ALUAddr[ADDR_WIDTH+1:2].
REQ-017 For a good write, RAM[index] SHALL be updated with the latched data on the edge entering DONE, and ValidMemData SHALL pulse.
REQ-018 For a good read, RAM[index] SHALL be captured into the output register on the edge entering DONE, and DataIO SHALL be driven with it only during DONE.
REQ-019 For a fault, RAM SHALL be unchanged, DataIO SHALL not be driven, and AddrFault SHALL pulse while ValidMemData stays low.
REQ-020 From DONE the block SHALL go to RELEASE, and SHALL return to IDLE on the first edge where MemIO is 00 or 11; a request held at 01/10 SHALL never be serviced twice.
REQ-021 MemBusy SHALL be high in WAIT, DONE and RELEASE, and low in IDLE.
REQ-022 Changes to MemIO, ALUAddr or DataIO after accept SHALL have no effect on the request in progress.
REQ-023 ValidMemData and AddrFault SHALL never be high in the same cycle.

Reset
REQ-024 While rst_n is low, the block SHALL force state IDLE, counter 0, and ValidMemData, AddrFault and MemBusy low, with DataIO at high-Z.
REQ-025 A reset asserted mid-request SHALL abort the request; a write not yet committed SHALL not be performed.
REQ-026 RAM contents SHALL not be cleared by reset.
REQ-027 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-028 Write/read: with WAIT_STATES=2, write 0xDEADBEEF to 0x10, then read 0x10 -> ValidMemData pulses 3 edges after each accept, and DataIO=0xDEADBEEF during the read pulse.
REQ-029 Zero wait: with WAIT_STATES=0, read 0x0 after writing 0x12345678 -> ValidMemData pulses 1 edge after accept with the correct data.
REQ-030 Fault: write to 0x11, then to 0x1000 (ADDR_WIDTH=10) -> AddrFault pulses each time, no ValidMemData, and a following read of 0x10 is unchanged.
REQ-031 Held request: MemIO held at 01 for 10 cycles -> exactly one ValidMemData pulse, MemBusy high until MemIO returns to 00.
REQ-032 Reset mid-write: rst_n low during WAIT of a write of 0xA5A5A5A5 to 0x20 -> after reset, a read of 0x20 returns the old value and outputs are low during reset.
REQ-033 Ignore 11: MemIO=11 in IDLE -> no state change, MemBusy low, DataIO at high-Z.
